// File: rtl/ks_note_sequencer_if.sv
// Pattern-write bus from the register map and the period/pluck pair sent to the KS core.
interface ks_note_sequencer_if #(
   parameter int unsigned STEPS    = 8,
   parameter int unsigned PERIOD_W = 8,
   parameter int unsigned DUR_W    = 8
);
   localparam int unsigned AW = $clog2(STEPS);

   logic                cfg_we;
   logic [AW-1:0]       cfg_addr;
   logic [PERIOD_W-1:0] cfg_period;
   logic [DUR_W-1:0]    cfg_dur;
   logic [PERIOD_W-1:0] ks_period;
   logic                ks_pluck;

   modport master (
      output cfg_we, cfg_addr, cfg_period, cfg_dur,
      input  ks_period, ks_pluck
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_period, cfg_dur,
      output ks_period, ks_pluck
   );
endinterface

// File: rtl/ks_note_sequencer.sv
// Step sequencer for the Karplus-Strong engine: walks a pattern RAM, sets the period,
// plucks the string and holds each step for a number of I2S frames.
module ks_note_sequencer #(
   parameter int unsigned STEPS        = 8,
   parameter int unsigned PERIOD_W     = 8,
   parameter int unsigned DUR_W        = 8,
   parameter int unsigned PLUCK_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   ks_note_sequencer_if.slave       bus,
   input  logic                     enable,
   input  logic                     loop,
   input  logic [$clog2(STEPS):0]   num_steps,
   input  logic                     sample_tick,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic                     busy,
   output logic                     done
);
   localparam int unsigned AW = $clog2(STEPS);
   localparam int unsigned PW = $clog2(PLUCK_CYCLES + 1);
   localparam logic [AW:0] STEPS_N = (AW + 1)'(STEPS);
   localparam logic [AW:0] ONE_N   = (AW + 1)'(1);

   typedef enum logic [2:0] {StIdle, StLoad, StEval, StPluck, StHold, StAdv, StDone} state_e;

   state_e state_q, state_d;

   logic [PERIOD_W-1:0] mem_period [STEPS];
   logic [DUR_W-1:0]    mem_dur    [STEPS];
   logic [PERIOD_W-1:0] rd_period_q;
   logic [DUR_W-1:0]    rd_dur_q;

   logic [AW-1:0]       step_q;
   logic [DUR_W-1:0]    frame_q;
   logic [PW-1:0]       pluck_cnt_q;
   logic [PERIOD_W-1:0] period_q;

   logic [AW:0] steps_eff;
   logic        last_step;
   logic        wrap;
   logic        pluck_last;
   logic        hold_over;

   assign steps_eff  = (num_steps > STEPS_N) ? STEPS_N : num_steps;
   // A shortened pattern (step already past the new end) is treated as the last step.
   assign last_step  = (steps_eff == '0) || ({1'b0, step_q} >= steps_eff - ONE_N);
   assign wrap       = last_step && loop && (steps_eff != '0);
   assign pluck_last = (pluck_cnt_q == PW'(PLUCK_CYCLES - 1));
   assign hold_over  = (frame_q >= rd_dur_q);

   // Pattern RAM: no reset, read-before-write on the registered read port.
   always_ff @(posedge clk) begin
      if (bus.cfg_we) begin
         mem_period[bus.cfg_addr] <= bus.cfg_period;
         mem_dur[bus.cfg_addr]    <= bus.cfg_dur;
      end
      if (state_q == StLoad) begin
         rd_period_q <= mem_period[step_q];
         rd_dur_q    <= mem_dur[step_q];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle:  state_d = (steps_eff == '0) ? StDone : StLoad;
            StLoad:  state_d = StEval;
            StEval: begin
               if (rd_dur_q == '0)         state_d = StAdv;
               else if (rd_period_q == '0) state_d = StHold;
               else                        state_d = StPluck;
            end
            StPluck: if (pluck_last) state_d = StHold;
            StHold:  if (hold_over)  state_d = StAdv;
            StAdv:   state_d = (last_step && !wrap) ? StDone : StLoad;
            StDone:  state_d = StDone;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q      <= '0;
         frame_q     <= '0;
         pluck_cnt_q <= '0;
         period_q    <= '0;
      end else if (!enable) begin
         step_q      <= '0;
         frame_q     <= '0;
         pluck_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               step_q  <= '0;
               frame_q <= '0;
            end
            StLoad: begin
               frame_q     <= '0;
               pluck_cnt_q <= '0;
            end
            StEval: begin
               if (rd_dur_q != '0 && rd_period_q != '0) period_q <= rd_period_q;
            end
            StPluck: begin
               pluck_cnt_q <= pluck_last ? '0 : pluck_cnt_q + PW'(1);
               if (sample_tick) frame_q <= frame_q + DUR_W'(1);
            end
            StHold: begin
               if (hold_over)        frame_q <= '0;
               else if (sample_tick) frame_q <= frame_q + DUR_W'(1);
            end
            StAdv: begin
               if (!last_step) step_q <= step_q + AW'(1);
               else if (wrap)  step_q <= '0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      bus.ks_pluck = 1'b0;
      unique case (state_q)
         StLoad, StEval, StHold, StAdv: busy = 1'b1;
         StPluck: begin
            busy         = 1'b1;
            bus.ks_pluck = 1'b1;
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   assign bus.ks_period = period_q;
   assign step_idx      = step_q;
endmodule

// File: tb/tb_ks_note_sequencer.sv
// Bench for ks_note_sequencer: directed scenarios with literal expectations plus a random
// phase, all compared every cycle against a countdown-style behavioural model.
module tb_ks_note_sequencer;
   localparam int STEPS = 8;
   localparam int PC    = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       loop;
   logic [3:0] num_steps;
   logic       sample_tick;
   logic [2:0] step_idx;
   logic       busy;
   logic       done;

   ks_note_sequencer_if #(.STEPS(STEPS), .PERIOD_W(8), .DUR_W(8)) bus ();

   ks_note_sequencer #(
      .STEPS(STEPS), .PERIOD_W(8), .DUR_W(8), .PLUCK_CYCLES(PC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .enable(enable), .loop(loop),
      .num_steps(num_steps), .sample_tick(sample_tick), .step_idx(step_idx),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: pattern copy plus countdowns describing where the current step is.
   int m_per [STEPS];
   int m_dur [STEPS];
   int m_active = 0, m_done = 0, m_step = 0, m_setup = 0, m_adv = 0;
   int m_pluck = 0, m_frames = 0, m_period = 0, e_per = 0, e_dur = 0;

   int plucks[$];
   bit prev_pluck = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic model_step();
      int ns;
      int last;
      ns = (num_steps > STEPS) ? STEPS : int'(num_steps);
      if (rst) begin
         m_active = 0; m_done = 0; m_step = 0; m_setup = 0; m_adv = 0;
         m_pluck = 0; m_frames = 0; m_period = 0;
      end else if (!enable) begin
         m_active = 0; m_done = 0; m_step = 0; m_setup = 0; m_adv = 0;
         m_pluck = 0; m_frames = 0;
      end else if (m_done != 0) begin
         m_done = 1;
      end else if (m_active == 0) begin
         if (ns == 0) m_done = 1;
         else begin m_active = 1; m_step = 0; m_setup = 2; end
      end else if (m_setup == 2) begin
         e_per = m_per[m_step]; e_dur = m_dur[m_step]; m_frames = 0; m_setup = 1;
      end else if (m_setup == 1) begin
         m_setup = 0;
         if (e_dur == 0) m_adv = 1;
         else if (e_per != 0) begin m_period = e_per; m_pluck = PC; end
      end else if (m_adv != 0) begin
         m_adv = 0;
         last = (ns == 0 || m_step >= ns - 1) ? 1 : 0;
         if (last == 0) begin m_step++; m_setup = 2; end
         else if (loop && ns != 0) begin m_step = 0; m_setup = 2; end
         else begin m_active = 0; m_done = 1; end
      end else if (m_pluck > 0) begin
         m_pluck--;
         if (sample_tick) m_frames++;
      end else if (m_frames >= e_dur) begin
         m_adv = 1; m_frames = 0;
      end else if (sample_tick) begin
         m_frames++;
      end
      if (bus.cfg_we) begin
         m_per[bus.cfg_addr] = bus.cfg_period;
         m_dur[bus.cfg_addr] = bus.cfg_dur;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("ks_period", int'(bus.ks_period), m_period);
      chk("ks_pluck", int'(bus.ks_pluck), (m_pluck > 0) ? 1 : 0);
      chk("step_idx", int'(step_idx), m_step);
      chk("busy", int'(busy), m_active);
      chk("done", int'(done), m_done);
      if (bus.ks_pluck && !prev_pluck) plucks.push_back(int'(bus.ks_period));
      prev_pluck  = bus.ks_pluck;
      sample_tick = 1'b0;
      bus.cfg_we  = 1'b0;
   endtask

   task automatic write_step(input int a, input int p, input int d);
      bus.cfg_we     = 1'b1;
      bus.cfg_addr   = 3'(a);
      bus.cfg_period = 8'(p);
      bus.cfg_dur    = 8'(d);
      cycle();
   endtask

   // Runs with a tick every 'gap' cycles until done rises or the budget expires.
   task automatic run_to_done(input int gap, input int budget);
      for (int i = 0; i < budget && !done; i++) begin
         if (i % gap == gap - 1) sample_tick = 1'b1;
         cycle();
      end
      chk("done_within_budget", int'(done), 1);
   endtask

   task automatic stop_run();
      enable = 1'b0;
      cycle();
   endtask

   initial begin
      bit saw_done;
      rst = 1'b1; enable = 1'b0; loop = 1'b0; num_steps = 4'd0; sample_tick = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_period = '0; bus.cfg_dur = '0;
      cycle();
      cycle();
      chk("reset_ks_pluck", int'(bus.ks_pluck), 0);
      chk("reset_ks_period", int'(bus.ks_period), 0);
      chk("reset_step_idx", int'(step_idx), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst = 1'b0;
      for (int a = 0; a < STEPS; a++) write_step(a, 0, 0);

      // Single note {32,3}: pluck visible after 3 edges for 4 cycles, done two edges after tick 3.
      write_step(0, 32, 3);
      num_steps = 4'd1; enable = 1'b1;
      cycle(); cycle();
      chk("single_no_pluck_yet", int'(bus.ks_pluck), 0);
      cycle();
      chk("single_pluck_start", int'(bus.ks_pluck), 1);
      chk("single_period", int'(bus.ks_period), 32);
      cycle(); cycle(); cycle();
      chk("single_pluck_last", int'(bus.ks_pluck), 1);
      cycle();
      chk("single_pluck_end", int'(bus.ks_pluck), 0);
      for (int k = 0; k < 3; k++) begin
         cycle(); cycle();
         sample_tick = 1'b1;
         cycle();
      end
      chk("single_not_done_yet", int'(done), 0);
      cycle(); cycle();
      chk("single_done", int'(done), 1);
      chk("single_period_held", int'(bus.ks_period), 32);
      stop_run();

      // Rest and skip steps.
      write_step(0, 40, 2); write_step(1, 0, 2); write_step(2, 50, 0); write_step(3, 60, 1);
      num_steps = 4'd4; plucks.delete(); enable = 1'b1;
      run_to_done(5, 300);
      chk("rest_pluck_count", plucks.size(), 2);
      if (plucks.size() == 2) begin
         chk("rest_pluck0", plucks[0], 40);
         chk("rest_pluck1", plucks[1], 60);
      end
      stop_run();

      // Loop wrap over two steps, one tick per step.
      write_step(0, 20, 1); write_step(1, 30, 1);
      num_steps = 4'd2; loop = 1'b1; plucks.delete(); enable = 1'b1; saw_done = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (i % 10 == 9) sample_tick = 1'b1;
         cycle();
         if (done) saw_done = 1'b1;
      end
      chk("loop_never_done", int'(saw_done), 0);
      chk("loop_pluck_count", plucks.size(), 6);
      if (plucks.size() == 6)
         for (int i = 0; i < 6; i++) chk("loop_pluck_period", plucks[i], (i % 2 == 0) ? 20 : 30);
      loop = 1'b0;
      stop_run();

      // Abort during the second pluck cycle, then restart from step 0.
      enable = 1'b1;
      cycle(); cycle(); cycle(); cycle();
      chk("abort_in_pluck", int'(bus.ks_pluck), 1);
      enable = 1'b0;
      cycle();
      chk("abort_pluck_low", int'(bus.ks_pluck), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_step", int'(step_idx), 0);
      enable = 1'b1;
      cycle(); cycle(); cycle();
      chk("restart_pluck", int'(bus.ks_pluck), 1);
      chk("restart_step", int'(step_idx), 0);
      chk("restart_period", int'(bus.ks_period), 20);
      stop_run();

      // Rewrite step 1 while step 0 is holding.
      write_step(0, 10, 2); write_step(1, 11, 1);
      num_steps = 4'd2; plucks.delete(); enable = 1'b1;
      for (int i = 0; i < 8; i++) cycle();
      write_step(1, 99, 1);
      run_to_done(4, 300);
      chk("wr_pluck_count", plucks.size(), 2);
      if (plucks.size() == 2) begin
         chk("wr_pluck0", plucks[0], 10);
         chk("wr_pluck1", plucks[1], 99);
      end
      stop_run();

      // Empty pattern goes straight to done.
      num_steps = 4'd0; plucks.delete(); enable = 1'b1;
      cycle();
      chk("empty_done", int'(done), 1);
      cycle(); cycle(); cycle();
      chk("empty_no_pluck", plucks.size(), 0);
      stop_run();

      // Random traffic.
      num_steps = 4'd3; enable = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 7) == 0) begin
            bus.cfg_we     = 1'b1;
            bus.cfg_addr   = 3'($urandom_range(0, STEPS - 1));
            bus.cfg_period = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            bus.cfg_dur    = 8'($urandom_range(0, 3));
         end
         sample_tick = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 299) == 0) enable = ~enable;
         if ($urandom_range(0, 99) == 0) num_steps = 4'($urandom_range(0, 10));
         if ($urandom_range(0, 99) == 0) loop = ~loop;
         if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
